// File: rtl/cube_pkg.sv
// Shared definitions for the cube move engine: face indices, colours, move encoding,
// FSM states and the solved reference state.
package cube_pkg;

  localparam int NUM_FACES = 6;

  localparam logic [2:0] FACE_F = 3'd0;
  localparam logic [2:0] FACE_B = 3'd1;
  localparam logic [2:0] FACE_L = 3'd2;
  localparam logic [2:0] FACE_R = 3'd3;
  localparam logic [2:0] FACE_U = 3'd4;
  localparam logic [2:0] FACE_D = 3'd5;

  localparam logic [2:0] COL_WHITE   = 3'd0;
  localparam logic [2:0] COL_YELLOW  = 3'd1;
  localparam logic [2:0] COL_BLUE    = 3'd2;
  localparam logic [2:0] COL_GREEN   = 3'd3;
  localparam logic [2:0] COL_RED     = 3'd4;
  localparam logic [2:0] COL_MAGENTA = 3'd5;

  // The encoding doubles as the number of clockwise quarter turns to apply.
  typedef enum logic [1:0] {
    DIR_NOP  = 2'b00,
    DIR_CW   = 2'b01,
    DIR_HALF = 2'b10,
    DIR_CCW  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TURN   = 2'd1,
    ST_NOTIFY = 2'd2
  } state_e;

  // One face: sticker index = row*3 + col as drawn on the net.
  typedef logic [0:8][2:0] face_t;
  typedef face_t cube_t [NUM_FACES];

  localparam cube_t SOLVED_CUBE = '{
    {9{COL_WHITE}}, {9{COL_YELLOW}}, {9{COL_BLUE}},
    {9{COL_GREEN}}, {9{COL_RED}},    {9{COL_MAGENTA}}
  };

  function automatic logic [3:0] ix(input int v);
    return 4'(v);
  endfunction

  function automatic logic is_solved(input cube_t c);
    logic ok;
    ok = 1'b1;
    for (int f = 0; f < NUM_FACES; f++) begin
      for (int i = 1; i < 9; i++) begin
        if (c[3'(f)][ix(i)] != c[3'(f)][4'd0]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/cube_move_engine_if.sv
// Move command channel into the cube move engine.
// A command transfers on a rising clk edge where move_valid && move_ready; the master
// holds face/dir stable with move_valid high until then, and nothing is queued.
interface cube_move_engine_if;
  logic       move_valid;
  logic       move_ready;
  logic [2:0] move_face;
  logic [1:0] move_dir;

  modport master (output move_valid, output move_face, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_face, input move_dir, output move_ready);
endinterface

// File: rtl/cube_turn_cw.sv
// Combinational single clockwise quarter turn of the selected face; every edge-cycle
// source is read from the pre-turn input.
module cube_turn_cw
  import cube_pkg::*;
(
  input  logic [2:0] face_i,
  input  cube_t      cube_i,
  output cube_t      cube_o
);

  localparam logic [0:8][3:0] ROT_CW = {4'd6, 4'd3, 4'd0, 4'd7, 4'd4, 4'd1, 4'd8, 4'd5, 4'd2};

  always_comb begin
    cube_o = cube_i;
    if (face_i < 3'd6) begin
      for (int i = 0; i < 9; i++) begin
        cube_o[face_i][ix(i)] = cube_i[face_i][ROT_CW[ix(i)]];
      end
    end
    for (int k = 0; k < 3; k++) begin
      case (face_i)
        FACE_U: begin
          cube_o[FACE_L][ix(k)] = cube_i[FACE_F][ix(k)];
          cube_o[FACE_B][ix(k)] = cube_i[FACE_L][ix(k)];
          cube_o[FACE_R][ix(k)] = cube_i[FACE_B][ix(k)];
          cube_o[FACE_F][ix(k)] = cube_i[FACE_R][ix(k)];
        end
        FACE_D: begin
          cube_o[FACE_R][ix(6+k)] = cube_i[FACE_F][ix(6+k)];
          cube_o[FACE_B][ix(6+k)] = cube_i[FACE_R][ix(6+k)];
          cube_o[FACE_L][ix(6+k)] = cube_i[FACE_B][ix(6+k)];
          cube_o[FACE_F][ix(6+k)] = cube_i[FACE_L][ix(6+k)];
        end
        FACE_F: begin
          cube_o[FACE_U][ix(6+k)]   = cube_i[FACE_L][ix(8-3*k)];
          cube_o[FACE_R][ix(3*k)]   = cube_i[FACE_U][ix(6+k)];
          cube_o[FACE_D][ix(k)]     = cube_i[FACE_R][ix(6-3*k)];
          cube_o[FACE_L][ix(2+3*k)] = cube_i[FACE_D][ix(k)];
        end
        FACE_R: begin
          cube_o[FACE_U][ix(2+3*k)] = cube_i[FACE_F][ix(2+3*k)];
          cube_o[FACE_B][ix(6-3*k)] = cube_i[FACE_U][ix(2+3*k)];
          cube_o[FACE_D][ix(2+3*k)] = cube_i[FACE_B][ix(6-3*k)];
          cube_o[FACE_F][ix(2+3*k)] = cube_i[FACE_D][ix(2+3*k)];
        end
        FACE_L: begin
          cube_o[FACE_F][ix(3*k)]   = cube_i[FACE_U][ix(3*k)];
          cube_o[FACE_D][ix(3*k)]   = cube_i[FACE_F][ix(3*k)];
          cube_o[FACE_B][ix(8-3*k)] = cube_i[FACE_D][ix(3*k)];
          cube_o[FACE_U][ix(3*k)]   = cube_i[FACE_B][ix(8-3*k)];
        end
        FACE_B: begin
          cube_o[FACE_U][ix(k)]     = cube_i[FACE_R][ix(2+3*k)];
          cube_o[FACE_L][ix(3*k)]   = cube_i[FACE_U][ix(2-k)];
          cube_o[FACE_D][ix(6+k)]   = cube_i[FACE_L][ix(3*k)];
          cube_o[FACE_R][ix(2+3*k)] = cube_i[FACE_D][ix(8-k)];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cube_move_engine.sv
// Holds the 54-sticker cube and applies face moves as a sequence of registered
// clockwise quarter turns, pulsing redraw once per completed command.
module cube_move_engine
  import cube_pkg::*;
#(
  parameter int MOVE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  cube_move_engine_if.slave     mv,
  output face_t                 f1,
  output face_t                 f2,
  output face_t                 f3,
  output face_t                 f4,
  output face_t                 f5,
  output face_t                 f6,
  output logic                  redraw,
  output logic                  solved,
  output logic [MOVE_CNT_W-1:0] move_count,
  output state_e                dbg_state_o
);

  state_e                state_q, state_d;
  cube_t                 faces_q, faces_d;
  cube_t                 turned;
  logic [1:0]            turns_q, turns_d;
  logic [2:0]            face_q, face_d;
  logic                  solved_q, solved_d;
  logic [MOVE_CNT_W-1:0] count_q, count_d;

  cube_turn_cw u_turn (
    .face_i (face_q),
    .cube_i (faces_q),
    .cube_o (turned)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      faces_q  <= SOLVED_CUBE;
      turns_q  <= 2'd0;
      face_q   <= 3'd0;
      solved_q <= 1'b1;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      faces_q  <= faces_d;
      turns_q  <= turns_d;
      face_q   <= face_d;
      solved_q <= solved_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    faces_d  = faces_q;
    turns_d  = turns_q;
    face_d   = face_q;
    count_d  = count_q;
    solved_d = solved_q;
    case (state_q)
      ST_IDLE: begin
        if (mv.move_valid) begin
          count_d = count_q + MOVE_CNT_W'(1);
          face_d  = mv.move_face;
          if (mv.move_face >= 3'd6) begin
            faces_d = SOLVED_CUBE;
            state_d = ST_NOTIFY;
          end else if (mv.move_dir == DIR_NOP) begin
            state_d = ST_NOTIFY;
          end else begin
            turns_d = mv.move_dir;
            state_d = ST_TURN;
          end
        end
      end
      ST_TURN: begin
        faces_d = turned;
        turns_d = turns_q - 2'd1;
        if (turns_q == 2'd1) state_d = ST_NOTIFY;
      end
      ST_NOTIFY: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // solved must already be valid while redraw is high, so compute it from the final state.
    if (state_d == ST_NOTIFY) solved_d = is_solved(faces_d);
  end

  assign mv.move_ready = (state_q == ST_IDLE);
  assign redraw        = (state_q == ST_NOTIFY);
  assign solved        = solved_q;
  assign move_count    = count_q;
  assign dbg_state_o   = state_q;

  assign f1 = faces_q[FACE_F];
  assign f2 = faces_q[FACE_B];
  assign f3 = faces_q[FACE_L];
  assign f4 = faces_q[FACE_R];
  assign f5 = faces_q[FACE_U];
  assign f6 = faces_q[FACE_D];

endmodule

// File: tb/tb_cube_move_engine.sv
// Bench for cube_move_engine: directed and random moves against a sticker-permutation
// model of the cube, checked by a redraw-driven scoreboard.
module tb_cube_move_engine;
  import cube_pkg::*;

  localparam int W  = 162;
  localparam int FF = 0, FB = 1, FL = 2, FR = 3, FU = 4, FD = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cube_move_engine_if mv ();
  face_t       f1, f2, f3, f4, f5, f6;
  logic        redraw, solved;
  logic [15:0] move_count;
  state_e      dbg_state;

  cube_move_engine #(.MOVE_CNT_W(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mv          (mv.slave),
    .f1          (f1),
    .f2          (f2),
    .f3          (f3),
    .f4          (f4),
    .f5          (f5),
    .f6          (f6),
    .redraw      (redraw),
    .solved      (solved),
    .move_count  (move_count),
    .dbg_state_o (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_solved_q[$];
  logic [15:0]  exp_cnt_q[$];
  int           exp_lat_q[$];
  int           acc_q[$];

  // Reference cube: flat sticker array, position = face*9 + index, value = colour.
  int          model[54];
  logic [15:0] model_cnt;
  bit          b2b;
  int          prev_acc, prev_lat;

  task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int pos(input int f, input int i);
    return f * 9 + i;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 54; p++) model[p] = p / 9;
  endfunction

  // Sticker at a moves to b, b to c, c to d, d back to a.
  function automatic void cyc4(input int a, input int b, input int c, input int d);
    int t;
    t = model[d];
    model[d] = model[c];
    model[c] = model[b];
    model[b] = model[a];
    model[a] = t;
  endfunction

  function automatic void model_cw(input int face);
    int base;
    base = face * 9;
    cyc4(base + 0, base + 2, base + 8, base + 6);
    cyc4(base + 1, base + 5, base + 7, base + 3);
    for (int k = 0; k < 3; k++) begin
      case (face)
        FU: cyc4(pos(FF, k), pos(FL, k), pos(FB, k), pos(FR, k));
        FD: cyc4(pos(FF, 6+k), pos(FR, 6+k), pos(FB, 6+k), pos(FL, 6+k));
        FF: cyc4(pos(FL, 8-3*k), pos(FU, 6+k), pos(FR, 3*k), pos(FD, 2-k));
        FR: cyc4(pos(FF, 2+3*k), pos(FU, 2+3*k), pos(FB, 6-3*k), pos(FD, 2+3*k));
        FL: cyc4(pos(FU, 3*k), pos(FF, 3*k), pos(FD, 3*k), pos(FB, 8-3*k));
        FB: cyc4(pos(FR, 2+3*k), pos(FU, k), pos(FL, 6-3*k), pos(FD, 8-k));
        default: ;
      endcase
    end
  endfunction

  function automatic void model_apply(input int face, input int dir);
    if (face >= 6) model_reset();
    else for (int q = 0; q < dir; q++) model_cw(face);
  endfunction

  function automatic logic model_solved();
    logic ok;
    ok = 1'b1;
    for (int f = 0; f < 6; f++)
      for (int i = 1; i < 9; i++)
        if (model[f*9+i] != model[f*9]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [W-1:0] v;
    v = '0;
    for (int p = 0; p < 54; p++) v[p*3 +: 3] = 3'(model[p]);
    return v;
  endfunction

  function automatic logic [W-1:0] dut_vec();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) begin
      v[(0*9+i)*3 +: 3] = f1[i];
      v[(1*9+i)*3 +: 3] = f2[i];
      v[(2*9+i)*3 +: 3] = f3[i];
      v[(3*9+i)*3 +: 3] = f4[i];
      v[(4*9+i)*3 +: 3] = f5[i];
      v[(5*9+i)*3 +: 3] = f6[i];
    end
    return v;
  endfunction

  // Scoreboard monitor: every redraw pops one expected command result.
  always @(negedge clk) begin
    if (resetn && redraw) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_redraw: got redraw=1 expected no pending command (t=%0t)", $time);
      end else begin
        logic [W-1:0] e_vec;
        logic         e_sol;
        logic [15:0]  e_cnt;
        int           e_lat, a_cyc;
        e_vec = exp_q.pop_front();
        e_sol = exp_solved_q.pop_front();
        e_cnt = exp_cnt_q.pop_front();
        e_lat = exp_lat_q.pop_front();
        a_cyc = acc_q.pop_front();
        check_val("stickers", dut_vec(), e_vec);
        check_val("solved", W'(solved), W'(e_sol));
        check_val("move_count", W'(move_count), W'(e_cnt));
        check_val("latency", W'(cyc - a_cyc), W'(e_lat));
        check_val("ready_in_notify", W'(mv.move_ready), W'(0));
      end
    end
  end

  task automatic send_cmd(input int face, input int dir);
    bit ok;
    int acc, lat;
    ok = 1'b0;
    mv.move_face  = 3'(face);
    mv.move_dir   = 2'(dir);
    mv.move_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (mv.move_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got move_ready=0 for 20 cycles expected 1");
      mv.move_valid = 1'b0;
      b2b = 1'b0;
      return;
    end
    acc = cyc;
    lat = (face >= 6 || dir == 0) ? 1 : dir + 1;
    if (b2b) check_val("accept_interval", W'(acc - prev_acc), W'(prev_lat + 1));
    model_apply(face, dir);
    model_cnt = model_cnt + 16'd1;
    exp_q.push_back(model_vec());
    exp_solved_q.push_back(model_solved());
    exp_cnt_q.push_back(model_cnt);
    exp_lat_q.push_back(lat);
    acc_q.push_back(acc);
    @(posedge clk);
    #1;
    prev_acc = acc;
    prev_lat = lat;
    b2b = 1'b1;
  endtask

  task automatic idle(input int n);
    mv.move_valid = 1'b0;
    b2b = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    mv.move_valid = 1'b0;
    b2b = 1'b0;
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    check_val("drain", W'(exp_q.size()), W'(0));
  endtask

  task automatic check_quiet(input string name);
    check_val({name, "_stickers"}, dut_vec(), model_vec());
    check_val({name, "_solved"}, W'(solved), W'(1));
    check_val({name, "_ready"}, W'(mv.move_ready), W'(1));
    check_val({name, "_redraw"}, W'(redraw), W'(0));
    check_val({name, "_count"}, W'(move_count), W'(0));
  endtask

  task automatic do_reset();
    mv.move_valid = 1'b0;
    b2b = 1'b0;
    resetn = 1'b0;
    model_reset();
    model_cnt = 16'd0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    resetn = 1'b1;
  endtask

  initial begin
    mv.move_valid = 1'b0;
    mv.move_face  = 3'd0;
    mv.move_dir   = 2'd0;
    b2b = 1'b0;
    prev_acc = 0;
    prev_lat = 0;
    model_reset();
    model_cnt = 16'd0;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_quiet("post_reset");
    end

    // F clockwise, with colour spot-checks on the four touched edge strips.
    send_cmd(FF, 1);
    wait_drain();
    for (int k = 0; k < 3; k++) begin
      check_val("f_cw_u_row2", W'(f5[6+k]), W'(2));
      check_val("f_cw_r_col0", W'(f4[3*k]), W'(4));
      check_val("f_cw_d_row0", W'(f6[k]), W'(3));
      check_val("f_cw_l_col2", W'(f3[2+3*k]), W'(5));
    end

    send_cmd(6, 0);
    send_cmd(FR, 1);
    send_cmd(FR, 3);
    wait_drain();
    check_val("r_rinv_solved", W'(solved), W'(1));

    send_cmd(FU, 2);
    send_cmd(FU, 2);
    send_cmd(FL, 0);
    send_cmd(7, 1);
    wait_drain();

    do_reset();
    repeat (6) begin
      send_cmd(FR, 1);
      send_cmd(FU, 1);
      send_cmd(FR, 3);
      send_cmd(FU, 3);
    end
    wait_drain();
    check_val("sexy_x6_count", W'(move_count), W'(24));
    check_val("sexy_x6_solved", W'(solved), W'(1));

    // Reset in the middle of a B turn with the command held throughout.
    idle(2);
    mv.move_face  = 3'(FB);
    mv.move_dir   = 2'd1;
    mv.move_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_turn_ready", W'(mv.move_ready), W'(0));
    resetn = 1'b0;
    #1;
    model_reset();
    model_cnt = 16'd0;
    b2b = 1'b0;
    check_quiet("mid_turn_reset");
    repeat (2) begin
      @(negedge clk);
      check_quiet("in_reset");
    end
    resetn = 1'b1;
    send_cmd(FB, 1);
    wait_drain();

    for (int n = 0; n < 60; n++) begin
      send_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    wait_drain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
